uart_tx_frame: RTL and testbench

- UART transmit-side framer: accepts a parallel byte with a one-cycle valid strobe, then serialises start bit, data LSB-first, optional parity and stop bit on TX_OUT.
- Runs on the already-divided TX clock, one bit period per CLK cycle.
- Counterpart of the receive-side parity check / deserialiser path. Parity convention is identical: PAR_TYP=0 even, PAR_TYP=1 odd.

---
 rtl/uart_tx_frame_pkg.sv | 25 ++
 rtl/uart_tx_frame_if.sv | 30 +++
 rtl/uart_parity_calc.sv | 25 ++
 rtl/uart_tx_frame.sv | 131 +++++++++++++
 tb/tb_uart_tx_frame.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity types.
// Imported by both the TX framer and its parity helper so both ends agree on values.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;
    localparam logic IDLE_LVL  = 1'b1;

    localparam logic PAR_EVEN  = 1'b0;
    localparam logic PAR_ODD   = 1'b1;

    // Width of an index able to address every data bit of a frame.
    function automatic int cnt_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

endpackage : uart_pkg

// File: rtl/uart_tx_frame_if.sv
// Parallel-side and line-side signals of the UART TX framer.
// The master drives the byte request; the slave (framer) drives the line and Busy.
interface uart_tx_frame_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] P_DATA;
    logic             DATA_VALID;
    logic             PAR_EN;
    logic             PAR_TYP;
    logic             TX_OUT;
    logic             Busy;

    modport master (
        output P_DATA,
        output DATA_VALID,
        output PAR_EN,
        output PAR_TYP,
        input  TX_OUT,
        input  Busy
    );

    modport slave (
        input  P_DATA,
        input  DATA_VALID,
        input  PAR_EN,
        input  PAR_TYP,
        output TX_OUT,
        output Busy
    );
endinterface : uart_tx_frame_if

// File: rtl/uart_parity_calc.sv
// Combinational parity over a data word: even type gives ^data, odd type gives ~^data.
// Same equation as the receive-side checker so both ends share one definition.
module uart_parity_calc
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] data,
    input  logic             par_typ,
    output logic             parity
);

    logic [WIDTH-1:0] xor_chain;

    assign xor_chain[0] = data[0];

    generate
        for (genvar gi = 1; gi < WIDTH; gi++) begin : g_xor
            assign xor_chain[gi] = xor_chain[gi-1] ^ data[gi];
        end
    endgenerate

    assign parity = (par_typ == PAR_ODD) ? ~xor_chain[WIDTH-1] : xor_chain[WIDTH-1];

endmodule : uart_parity_calc

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, WIDTH data bits LSB first, optional parity, stop bit.
// One bit per CLK edge; TX_OUT and Busy are driven straight from flops.
module uart_tx_frame
    import uart_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic            CLK,
    input  logic            RST,
    uart_tx_frame_if.slave  tx_if
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);

    tx_state_e        state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [WIDTH-1:0] data_q,   data_d;
    logic             par_en_q, par_en_d;
    logic             parity_q, parity_d;
    logic             tx_q,     tx_d;
    logic             busy_q,   busy_d;

    logic             accept;
    logic             parity_calc;
    logic [CNT_W-1:0] next_idx;

    uart_parity_calc #(
        .WIDTH (WIDTH)
    ) u_parity (
        .data    (tx_if.P_DATA),
        .par_typ (tx_if.PAR_TYP),
        .parity  (parity_calc)
    );

    // A new frame may start from idle or directly out of a stop bit.
    assign accept   = tx_if.DATA_VALID && ((state_q == IDLE) || (state_q == STOP));
    assign next_idx = cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        parity_d = parity_q;
        tx_d     = tx_q;
        busy_d   = busy_q;

        if (accept) begin
            data_d   = tx_if.P_DATA;
            par_en_d = tx_if.PAR_EN;
            parity_d = parity_calc;
        end

        case (state_q)
            IDLE, STOP: begin
                if (accept) begin
                    state_d = START;
                    tx_d    = START_BIT;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    tx_d    = IDLE_LVL;
                    busy_d  = 1'b0;
                end
            end

            START: begin
                state_d = DATA;
                cnt_d   = '0;
                tx_d    = data_q[0];
                busy_d  = 1'b1;
            end

            // cnt_q always indexes the data bit currently on the line.
            DATA: begin
                busy_d = 1'b1;
                if (cnt_q == LAST_IDX) begin
                    cnt_d = '0;
                    if (par_en_q) begin
                        state_d = PARITY;
                        tx_d    = parity_q;
                    end else begin
                        state_d = STOP;
                        tx_d    = STOP_BIT;
                    end
                end else begin
                    cnt_d = next_idx;
                    tx_d  = data_q[next_idx];
                end
            end

            PARITY: begin
                state_d = STOP;
                tx_d    = STOP_BIT;
                busy_d  = 1'b1;
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                tx_d    = IDLE_LVL;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            data_q   <= '0;
            par_en_q <= 1'b0;
            parity_q <= 1'b0;
            tx_q     <= IDLE_LVL;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            parity_q <= parity_d;
            tx_q     <= tx_d;
            busy_q   <= busy_d;
        end
    end

    assign tx_if.TX_OUT = tx_q;
    assign tx_if.Busy   = busy_q;

endmodule : uart_tx_frame

// File: tb/tb_uart_tx_frame.sv
// Self-checking bench for uart_tx_frame: a queue-of-line-bits model checked every cycle,
// plus literal frame expectations for the directed cases and a randomized request phase.
module tb_uart_tx_frame;

    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    uart_tx_frame_if #(.WIDTH(WIDTH)) tx_if ();

    uart_tx_frame #(.WIDTH(WIDTH)) dut (
        .CLK   (clk),
        .RST   (rst_n),
        .tx_if (tx_if)
    );

    int tests = 0;
    int fails = 0;

    // Bits still to appear on the line; the front is the bit being driven right now.
    bit line_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [WIDTH-1:0] d, input logic pe, input logic pt);
        bit ones_odd;
        ones_odd = ($countones(d) % 2) == 1;
        line_q.push_back(1'b0);
        for (int i = 0; i < WIDTH; i++) line_q.push_back(d[i]);
        if (pe) line_q.push_back(ones_odd ^ pt);
        line_q.push_back(1'b1);
    endtask

    // Model: each edge retires the current bit; an empty line accepts a pending request.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                line_q.delete();
            end else begin
                if (line_q.size() > 0) void'(line_q.pop_front());
                if (line_q.size() == 0 && tx_if.DATA_VALID)
                    push_frame(tx_if.P_DATA, tx_if.PAR_EN, tx_if.PAR_TYP);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            check("line_tx",   tx_if.TX_OUT, (line_q.size() > 0) ? line_q[0] : 1'b1);
            check("line_busy", tx_if.Busy,   (line_q.size() > 0) ? 1'b1 : 1'b0);
        end
    end

    task automatic send(input logic [WIDTH-1:0] d, input logic pe, input logic pt);
        @(posedge clk);
        #1;
        tx_if.P_DATA     = d;
        tx_if.PAR_EN     = pe;
        tx_if.PAR_TYP    = pt;
        tx_if.DATA_VALID = 1'b1;
        @(posedge clk);
        #1;
        tx_if.DATA_VALID = 1'b0;
        tx_if.P_DATA     = WIDTH'($urandom);
        tx_if.PAR_EN     = 1'($urandom);
        tx_if.PAR_TYP    = 1'($urandom);
        $display("[TB] sent frame data=%0h par_en=%0b par_typ=%0b", d, pe, pt);
    endtask

    task automatic check_frame(input string name, input int n, input logic [15:0] exp,
                               input bit idle_after);
        logic [15:0] cap;
        logic [15:0] bcap;
        cap  = '0;
        bcap = '0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cap[i]  = tx_if.TX_OUT;
            bcap[i] = tx_if.Busy;
        end
        check({name, "_bits"}, cap, exp);
        check({name, "_busy"}, bcap, (32'd1 << n) - 32'd1);
        if (idle_after) begin
            @(negedge clk);
            check({name, "_idle_tx"},   tx_if.TX_OUT, 1'b1);
            check({name, "_idle_busy"}, tx_if.Busy,   1'b0);
        end
        $display("[TB] frame %s captured bits=%0h", name, cap);
    endtask

    task automatic wait_idle();
        bit done;
        done = 1'b0;
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            if (!tx_if.Busy && line_q.size() == 0) done = 1'b1;
        end
        check("idle_timeout", done, 1'b1);
    endtask

    initial begin
        logic [15:0] cap;

        // Reset held with a request pending: line stays idle.
        tx_if.P_DATA     = 8'h5A;
        tx_if.PAR_EN     = 1'b1;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.DATA_VALID = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("rst_tx",   tx_if.TX_OUT, 1'b1);
            check("rst_busy", tx_if.Busy,   1'b0);
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        tx_if.DATA_VALID = 1'b0;
        @(negedge clk);
        check("release_first_tx",   tx_if.TX_OUT, 1'b0);
        check("release_first_busy", tx_if.Busy,   1'b1);
        $display("[TB] reset release: first edge accepted");
        wait_idle();

        send(8'hA5, 1'b1, 1'b0);
        check_frame("a5_even", 11, 16'b1_0_10100101_0, 1'b1);

        send(8'hA5, 1'b1, 1'b1);
        check_frame("a5_odd", 11, 16'b1_1_10100101_0, 1'b1);

        send(8'h3C, 1'b0, 1'b0);
        check_frame("3c_nopar", 10, 16'b1_00111100_0, 1'b1);

        // Back-to-back: request lands on the stop cycle of frame 01.
        send(8'h01, 1'b1, 1'b0);
        cap = '0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            cap[i] = tx_if.TX_OUT;
        end
        check("b2b_first_bits", cap, 16'b1_00000001_0);
        @(posedge clk);
        #1;
        tx_if.P_DATA     = 8'hFF;
        tx_if.PAR_EN     = 1'b1;
        tx_if.PAR_TYP    = 1'b0;
        tx_if.DATA_VALID = 1'b1;
        @(negedge clk);
        check("b2b_stop_tx",   tx_if.TX_OUT, 1'b1);
        check("b2b_stop_busy", tx_if.Busy,   1'b1);
        @(posedge clk);
        #1;
        tx_if.DATA_VALID = 1'b0;
        tx_if.P_DATA     = 8'h00;
        $display("[TB] back-to-back request issued on stop cycle");
        check_frame("b2b_ff", 11, 16'b1_0_11111111_0, 1'b1);

        // Request and type change during DATA must not disturb frame 0F.
        send(8'h0F, 1'b1, 1'b0);
        fork
            begin
                repeat (3) @(posedge clk);
                #1;
                tx_if.P_DATA     = 8'h55;
                tx_if.PAR_TYP    = 1'b1;
                tx_if.DATA_VALID = 1'b1;
                @(posedge clk);
                #1;
                tx_if.DATA_VALID = 1'b0;
            end
        join_none
        check_frame("0f_ignore", 11, 16'b1_0_00001111_0, 1'b1);

        // Asynchronous reset during data bit 3 of frame C3.
        send(8'hC3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) @(negedge clk);
        check("mid_bit3_tx", tx_if.TX_OUT, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_tx",   tx_if.TX_OUT, 1'b1);
        check("mid_rst_busy", tx_if.Busy,   1'b0);
        $display("[TB] reset asserted mid-frame");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        send(8'hC3, 1'b1, 1'b1);
        check_frame("c3_after_rst", 11, 16'b1_1_11000011_0, 1'b1);

        // Random requests, including ones that land on stop cycles.
        for (int c = 0; c < 800; c++) begin
            @(posedge clk);
            #1;
            tx_if.DATA_VALID = ($urandom % 4) == 0;
            tx_if.P_DATA     = WIDTH'($urandom);
            tx_if.PAR_EN     = 1'($urandom);
            tx_if.PAR_TYP    = 1'($urandom);
        end
        tx_if.DATA_VALID = 1'b0;
        $display("[TB] random phase complete");
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_uart_tx_frame
